cordic_rotation_engine: RTL and testbench

Iterative circular CORDIC in rotation mode: it accepts a vector (x, y) and an angle z, then rotates the vector by z using one shift-add micro-rotation per clock. It consumes the values held in the CORDIC x/y/z working registers. Each iteration it produces their next values, and it owns the iteration counter, the arctangent constants and the start/valid handshake. It presents a single-cycle completion strobe to the downstream logic.

---
 rtl/cordic_rotation_engine.sv | 130 +++++++++++++
 tb/tb_cordic_rotation_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rotation_engine.sv
// Iterative circular CORDIC in rotation mode: one shift-add micro-rotation per clock,
// with a start/ready handshake and a single-cycle completion strobe.
module cordic_rotation_engine #(
  parameter int ITER = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [15:0]  x_in,
  input  logic signed [15:0]  y_in,
  input  logic signed [15:0]  z_in,
  output logic                ready,
  output logic                busy,
  output logic                valid_out,
  output logic signed [15:0]  x_out,
  output logic signed [15:0]  y_out,
  output logic signed [15:0]  z_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_IT = 4'(ITER - 1);

  state_t             state_q;
  logic [3:0]         i_q;
  logic signed [17:0] xr_q, yr_q;
  logic signed [15:0] zr_q;
  logic               valid_q;
  logic signed [15:0] x_out_q, y_out_q, z_out_q;

  logic signed [17:0] xr_d, yr_d, x_sh, y_sh;
  logic signed [15:0] zr_d, atan_c;
  logic               d_pos;

  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  always_comb begin
    case (i_q)
      4'd0:    atan_c = 16'sd12868;
      4'd1:    atan_c = 16'sd7596;
      4'd2:    atan_c = 16'sd4014;
      4'd3:    atan_c = 16'sd2037;
      4'd4:    atan_c = 16'sd1023;
      4'd5:    atan_c = 16'sd512;
      4'd6:    atan_c = 16'sd256;
      4'd7:    atan_c = 16'sd128;
      4'd8:    atan_c = 16'sd64;
      4'd9:    atan_c = 16'sd32;
      4'd10:   atan_c = 16'sd16;
      4'd11:   atan_c = 16'sd8;
      4'd12:   atan_c = 16'sd4;
      4'd13:   atan_c = 16'sd2;
      4'd14:   atan_c = 16'sd1;
      default: atan_c = 16'sd0;
    endcase
  end

  // Micro-rotation: zero residual angle rotates in the positive direction.
  always_comb begin
    d_pos = ~zr_q[15];
    x_sh  = xr_q >>> i_q;
    y_sh  = yr_q >>> i_q;
    if (d_pos) begin
      xr_d = xr_q - y_sh;
      yr_d = yr_q + x_sh;
      zr_d = zr_q - atan_c;
    end else begin
      xr_d = xr_q + y_sh;
      yr_d = yr_q - x_sh;
      zr_d = zr_q + atan_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 4'd0;
      xr_q    <= '0;
      yr_q    <= '0;
      zr_q    <= '0;
      valid_q <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            xr_q    <= 18'(x_in);
            yr_q    <= 18'(y_in);
            zr_q    <= z_in;
            i_q     <= 4'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          xr_q <= xr_d;
          yr_q <= yr_d;
          zr_q <= zr_d;
          i_q  <= i_q + 4'd1;
          if (i_q == LAST_IT) begin
            x_out_q <= sat16(xr_d);
            y_out_q <= sat16(yr_d);
            z_out_q <= zr_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready     = (state_q == IDLE);
  assign busy      = ~ready;
  assign valid_out = valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_rotation_engine.sv
// Scoreboard bench for cordic_rotation_engine: driver pushes model results, a negedge
// monitor pops and compares on every valid_out.
module tb_cordic_rotation_engine;
  localparam int ITER = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
  logic ready, busy, valid_out;
  logic signed [15:0] x_out, y_out, z_out;

  cordic_rotation_engine #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .ready(ready), .busy(busy), .valid_out(valid_out),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x, y, z;
    bit tc; int tx, ty, tol;
    bit zc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  bit hold_phase = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void chk_tol(string name, int act, int exp, int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endfunction

  // Angle constants derived from the arctangent itself, not copied from the design.
  function automatic int atan_ref(int i);
    real r = 1.0;
    for (int k = 0; k < i; k++) r = r / 2.0;
    return $rtoi($floor($atan(r) * 16384.0 + 0.5));
  endfunction

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(int x0, int y0, int z0);
    exp_t e;
    int x = x0, y = y0, z = z0, xn;
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); z = z - atan_ref(i);
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); z = z + atan_ref(i);
      end
      x = xn;
    end
    e.x = clamp16(x);
    e.y = clamp16(y);
    e.z = int'(16'(z) ^ 16'h8000) - 32768;
    e.tc = 1'b0; e.tx = 0; e.ty = 0; e.tol = 0; e.zc = 1'b0;
    return e;
  endfunction

  // Monitor
  int cyc = 0;
  bit vprev = 1'b0, rprev = 1'b0, has_last = 1'b0;
  int lx = 0, ly = 0, lz = 0;
  int last_hold = -1;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (rprev) begin
      chk("reset_x_out", int'(x_out), 0);
      chk("reset_y_out", int'(y_out), 0);
      chk("reset_z_out", int'(z_out), 0);
      chk("reset_valid", int'(valid_out), 0);
      lx = 0; ly = 0; lz = 0; has_last = 1'b1;
    end else if (valid_out) begin
      chk("single_cycle_valid", int'(vprev), 0);
      if (q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        me = q.pop_front();
        chk("x_out", int'(x_out), me.x);
        chk("y_out", int'(y_out), me.y);
        chk("z_out", int'(z_out), me.z);
        if (me.tc) begin
          chk_tol("x_out_target", int'(x_out), me.tx, me.tol);
          chk_tol("y_out_target", int'(y_out), me.ty, me.tol);
        end
        if (me.zc) chk_tol("z_residual", int'(z_out), 0, 2);
      end
      if (hold_phase) begin
        if (last_hold >= 0) chk("issue_interval", cyc - last_hold, ITER + 2);
        last_hold = cyc;
      end else begin
        last_hold = -1;
      end
      lx = int'(x_out); ly = int'(y_out); lz = int'(z_out); has_last = 1'b1;
    end else if (has_last) begin
      chk("hold_x_out", int'(x_out), lx);
      chk("hold_y_out", int'(y_out), ly);
      chk("hold_z_out", int'(z_out), lz);
    end
    vprev = valid_out;
    rprev = rst;
  end

  function automatic int rnd_angle();
    return int'($urandom_range(0, 51472)) - 25736;
  endfunction

  // Called at posedge+1; returns at posedge+1 with the engine back in IDLE.
  task automatic run_job(int x, int y, int z, bit tc, int tx, int ty, int tol, bit zc);
    exp_t e;
    int n;
    bit got;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_job", int'(ready), 1);
    e = model(x, y, z);
    e.tc = tc; e.tx = tx; e.ty = ty; e.tol = tol; e.zc = zc;
    x_in = 16'(x); y_in = 16'(y); z_in = 16'(z); start = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
    chk("busy_in_run", int'(busy), 1);
    n = 0; got = 1'b0;
    while (!got && n < ITER + 4) begin
      @(posedge clk); #1; n++;
      start = (n == 5);
      if (n == 5) begin
        x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'(rnd_angle());
      end
      if (valid_out) got = 1'b1;
    end
    chk("latency", n, ITER);
    // start during DONE must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_done", int'(ready), 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("ready_after_reset", int'(ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    run_job(9949, 0, 0, 1'b1, 16384, 0, 8, 1'b1);
    run_job(9949, 0, 12868, 1'b1, 11585, 11585, 8, 1'b0);
    run_job(9949, 0, -25736, 1'b1, 0, -16384, 8, 1'b0);
    run_job(32767, 32767, 12868, 1'b1, 0, 32767, 32767, 1'b0);
    run_job(-32768, -32768, 25736, 1'b0, 0, 0, 0, 1'b0);

    for (int k = 0; k < 20; k++)
      run_job(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
              rnd_angle(), 1'b0, 0, 0, 0, 1'b0);

    // Abort a job with a two-cycle reset in the middle of RUN.
    x_in = 16'sd9949; y_in = 16'sd0; z_in = 16'sd12868; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid_out), 0);
    chk("abort_x_out", int'(x_out), 0);
    chk("abort_y_out", int'(y_out), 0);
    chk("abort_z_out", int'(z_out), 0);
    repeat (ITER + 6) @(posedge clk);
    #1;

    // start held high: only IDLE cycles accept, results every ITER+2 cycles.
    @(negedge clk);
    hold_phase = 1'b1;
    for (int c = 0; c < 6 * (ITER + 2); c++) begin
      x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'(rnd_angle());
      start = 1'b1;
      if (ready) begin
        e = model(int'(x_in), int'(y_in), int'(z_in));
        q.push_back(e);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(posedge clk); #1;
    drain();
    repeat (ITER + 4) @(posedge clk);
    hold_phase = 1'b0;
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
